// File: rtl/mem_rmw_pkg.sv
// Shared processor definitions for the memory stage: FSM states and byte-lane selects.
// Pure declarations; no latency and no flow control.
package mem_rmw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } rmw_state_t;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  localparam int DM_AW = 11;

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte extract (zero-extended) and byte insert on a 32-bit word.
// Purely combinational, zero latency, no flow control.
module byte_lane_unit
  import mem_rmw_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_extract,
  output logic [31:0] o_insert
);

  always_comb begin
    o_extract = '0;
    o_insert  = i_word;
    case (i_lane)
      LANE_0: begin
        o_extract[7:0] = i_word[7:0];
        o_insert[7:0]  = i_byte;
      end
      LANE_1: begin
        o_extract[7:0]  = i_word[15:8];
        o_insert[15:8]  = i_byte;
      end
      LANE_2: begin
        o_extract[7:0]  = i_word[23:16];
        o_insert[23:16] = i_byte;
      end
      LANE_3: begin
        o_extract[7:0]  = i_word[31:24];
        o_insert[31:24] = i_byte;
      end
      default: begin
        o_extract = '0;
        o_insert  = i_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_rmw_stage.sv
// Memory stage sequencer: lw/lb/sw/sb against a synchronous data memory, sb as read-modify-write.
// Done at T+3 (lw/lb), T+2 (sw), T+4 (sb); one request at a time, start ignored while busy.
module mem_rmw_stage
  import mem_rmw_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             ByteOp,
  input  logic             Mem_WrEn,
  input  logic [31:0]      ALU_MEM_Addr,
  input  logic [31:0]      MEM_DataIn,
  output logic [DM_AW-1:0] dm_addr,
  output logic             dm_we,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  output logic [31:0]      MEM_DataOut,
  output logic             done,
  output logic             busy,
  output logic             misalign
);

  rmw_state_t       r_state;
  rmw_state_t       w_state_nxt;
  logic             r_byteop;
  logic             r_wren;
  logic [1:0]       r_lane;
  logic             r_misalign;
  logic [DM_AW-1:0] r_dm_addr;
  logic [31:0]      r_dm_wdata;
  logic [31:0]      r_dataout;
  logic [31:0]      w_extract;
  logic [31:0]      w_insert;
  logic             w_addr_unused;

  // Upper address bits are outside the data memory window.
  assign w_addr_unused = ^ALU_MEM_Addr[31:13];

  // The store byte is kept in the low lane of the latched write data.
  byte_lane_unit u_lane (
    .i_word    (dm_rdata),
    .i_lane    (r_lane),
    .i_byte    (r_dm_wdata[7:0]),
    .o_extract (w_extract),
    .o_insert  (w_insert)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_state_nxt = (Mem_WrEn && !ByteOp) ? ST_WR : ST_RD_REQ;
      ST_RD_REQ:  w_state_nxt = ST_RD_DATA;
      ST_RD_DATA: w_state_nxt = r_wren ? ST_WR : ST_DONE;
      ST_WR:      w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_byteop   <= 1'b0;
      r_wren     <= 1'b0;
      r_lane     <= LANE_0;
      r_misalign <= 1'b0;
      r_dm_addr  <= '0;
      r_dm_wdata <= '0;
      r_dataout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && start) begin
        r_byteop   <= ByteOp;
        r_wren     <= Mem_WrEn;
        r_lane     <= ByteOp ? ALU_MEM_Addr[1:0] : LANE_0;
        r_misalign <= !ByteOp && (ALU_MEM_Addr[1:0] != 2'b00);
        r_dm_addr  <= ALU_MEM_Addr[12:2];
        r_dm_wdata <= MEM_DataIn;
      end
      if (r_state == ST_RD_DATA) begin
        if (r_wren) r_dm_wdata <= w_insert;
        else        r_dataout  <= r_byteop ? w_extract : dm_rdata;
      end
    end
  end

  assign dm_addr     = r_dm_addr;
  assign dm_wdata    = r_dm_wdata;
  assign MEM_DataOut = r_dataout;
  assign dm_we       = (r_state == ST_WR);
  assign done        = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);
  assign misalign    = (r_state == ST_DONE) && r_misalign;

endmodule
